// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer scanout arbiter.
// Geometry, RAM width and FSM encodings used by the top and the line buffer.
package fb_pkg;
  localparam int FB_W      = 160;
  localparam int FB_H      = 144;
  localparam int FB_PIXELS = FB_W * FB_H;
  localparam int PIX_W     = 2;
  localparam int ADDR_W    = 15;

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  typedef enum logic {
    LAST_PPU,
    LAST_FETCH
  } last_t;

  // line*160 built from two shifts
  function automatic logic [ADDR_W-1:0] line_base(
    input logic [7:0] n
  );
    return (ADDR_W'(n) << 7) + (ADDR_W'(n) << 5);
  endfunction
endpackage

// File: rtl/fb_line_buffer.sv
// Ping-pong line storage: writes land in the back half,
// registered reads come from the front half.
module fb_line_buffer
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             swap,
  input  logic             wr_en,
  input  logic [7:0]       wr_idx,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [7:0]       rd_idx,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem0 [FB_W];
  logic [PIX_W-1:0] mem1 [FB_W];

  logic             front_q, front_d;
  logic [PIX_W-1:0] rd_q, rd_d;

  always_comb begin
    front_d = front_q ^ swap;
    rd_d    = '0;
    if (rd_idx < 8'(FB_W)) begin
      rd_d = front_q ? mem1[rd_idx] : mem0[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      front_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      front_q <= front_d;
      rd_q    <= rd_d;
    end
  end

  // back half is chosen from the pre-swap select
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      if (front_q) mem0[wr_idx] <= wr_data;
      else         mem1[wr_idx] <= wr_data;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Framebuffer RAM arbiter: round-robin between PPU writes and
// scanout line prefetch into a ping-pong line buffer.
module fb_scanout_arbiter
  import fb_pkg::*;
(
  input  logic              fbclk,
  input  logic              fbclk_rst,
  input  logic              line_req,
  input  logic [7:0]        line_num,
  input  logic              swap,
  input  logic              ppu_wr_valid,
  output logic              ppu_wr_ready,
  input  logic [ADDR_W-1:0] ppu_wr_addr,
  input  logic [PIX_W-1:0]  ppu_wr_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  input  logic [7:0]        pix_x,
  output logic [PIX_W-1:0]  pix_data,
  output logic              fetch_busy,
  output logic              underrun
);

  state_t            state_q, state_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        cx_q, cx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              cap_q, cap_d;
  last_t             last_q, last_d;
  logic              underrun_q, underrun_d;

  logic rd_pend;
  logic grant_rd;
  logic grant_ppu;
  logic ppu_in_range;

  always_comb begin
    rd_pend      = (state_q == FETCH) &&
                   (rx_q < 8'(FB_W));
    grant_rd     = rd_pend &&
                   (!ppu_wr_valid || last_q == LAST_PPU);
    grant_ppu    = ppu_wr_valid && !grant_rd;
    ppu_in_range = ppu_wr_addr < ADDR_W'(FB_PIXELS);

    state_d    = state_q;
    rx_d       = rx_q;
    cx_d       = cx_q;
    base_d     = base_q;
    cap_d      = 1'b0;
    last_d     = last_q;
    underrun_d = underrun_q;

    ppu_wr_ready = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;

    if (ppu_wr_valid && rd_pend) begin
      last_d = grant_rd ? LAST_FETCH : LAST_PPU;
    end

    if (grant_rd) begin
      ram_en   = 1'b1;
      ram_addr = base_q + ADDR_W'(rx_q);
      rx_d     = rx_q + 8'd1;
      cap_d    = 1'b1;
      cx_d     = rx_q;
    end else if (grant_ppu) begin
      ppu_wr_ready = 1'b1;
      if (ppu_in_range) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = ppu_wr_addr;
        ram_wdata = ppu_wr_data;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (line_req && line_num < 8'(FB_H)) begin
          base_d  = line_base(line_num);
          rx_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (line_req || swap) underrun_d = 1'b1;
        if (cap_q && cx_q == 8'(FB_W - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // keep the RAM side quiet while reset is held
    if (fbclk_rst) begin
      ppu_wr_ready = 1'b0;
      ram_en       = 1'b0;
      ram_we       = 1'b0;
      ram_addr     = '0;
      ram_wdata    = '0;
    end
  end

  always_ff @(posedge fbclk) begin
    if (fbclk_rst) begin
      state_q    <= IDLE;
      rx_q       <= '0;
      cx_q       <= '0;
      base_q     <= '0;
      cap_q      <= 1'b0;
      last_q     <= LAST_FETCH;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_q       <= rx_d;
      cx_q       <= cx_d;
      base_q     <= base_d;
      cap_q      <= cap_d;
      last_q     <= last_d;
      underrun_q <= underrun_d;
    end
  end

  fb_line_buffer u_lbuf (
    .clk     (fbclk),
    .rst     (fbclk_rst),
    .swap    (swap),
    .wr_en   (cap_q),
    .wr_idx  (cx_q),
    .wr_data (ram_rdata),
    .rd_idx  (pix_x),
    .rd_data (pix_data)
  );

  assign fetch_busy = (state_q == FETCH);
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Directed bench for fb_scanout_arbiter with a behavioural RAM
// and a pixel scoreboard.
module tb_fb_scanout_arbiter;
  import fb_pkg::*;

  logic              fbclk = 1'b0;
  logic              fbclk_rst;
  logic              line_req;
  logic [7:0]        line_num;
  logic              swap;
  logic              ppu_wr_valid;
  logic              ppu_wr_ready;
  logic [ADDR_W-1:0] ppu_wr_addr;
  logic [PIX_W-1:0]  ppu_wr_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [PIX_W-1:0]  ram_wdata;
  logic [PIX_W-1:0]  ram_rdata;
  logic [7:0]        pix_x;
  logic [PIX_W-1:0]  pix_data;
  logic              fetch_busy;
  logic              underrun;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];
  logic [PIX_W-1:0] mem [FB_PIXELS];

  always #5 fbclk = ~fbclk;

  fb_scanout_arbiter dut (
    .fbclk        (fbclk),
    .fbclk_rst    (fbclk_rst),
    .line_req     (line_req),
    .line_num     (line_num),
    .swap         (swap),
    .ppu_wr_valid (ppu_wr_valid),
    .ppu_wr_ready (ppu_wr_ready),
    .ppu_wr_addr  (ppu_wr_addr),
    .ppu_wr_data  (ppu_wr_data),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .pix_x        (pix_x),
    .pix_data     (pix_data),
    .fetch_busy   (fetch_busy),
    .underrun     (underrun)
  );

  always @(posedge fbclk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic cyc();
    @(posedge fbclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Entered in cycle 1 of a fetch; leaves in the first idle cycle.
  task automatic run_fetch(input bit contested,
                           input int base,
                           output int busy,
                           output int reads,
                           output int bad);
    bit rd;
    bit exp_rd;
    busy = 0;
    reads = 0;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      #1;
      if (!fetch_busy) break;
      busy++;
      rd = ram_en && !ram_we;
      if (rd) begin
        if (ram_addr !== ADDR_W'(base + reads)) bad++;
        reads++;
      end
      if (contested) begin
        exp_rd = (busy % 2 == 0) && (busy <= 320);
        if (rd !== exp_rd) bad++;
        if (ppu_wr_ready !== !exp_rd) bad++;
      end
      cyc();
      if (contested) begin
        ppu_wr_addr = ADDR_W'(16000 + busy % 160);
        ppu_wr_data = 2'(busy);
      end
    end
  endtask

  task automatic read_line(input int y);
    logic [31:0] e;
    for (int x = 0; x <= FB_W; x++) begin
      pix_x = (x == FB_W) ? 8'd200 : 8'(x);
      sb.push_back((x == FB_W) ? 32'd0 : 32'((x + y) & 3));
      cyc();
      e = sb.pop_front();
      chk($sformatf("pix_y%0d_x%0d", y, pix_x),
          32'(pix_data), e);
    end
  endtask

  int busy, reads, bad;

  initial begin
    for (int i = 0; i < FB_PIXELS; i++) begin
      mem[i] <= 2'((i % FB_W + i / FB_W) & 3);
    end
    fbclk_rst    = 1'b1;
    line_req     = 1'b0;
    line_num     = '0;
    swap         = 1'b0;
    ppu_wr_valid = 1'b0;
    ppu_wr_addr  = '0;
    ppu_wr_data  = '0;
    pix_x        = '0;

    repeat (3) cyc();
    chk("rst_busy", 32'(fetch_busy), 0);
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_pix", 32'(pix_data), 0);
    fbclk_rst = 1'b0;
    cyc();
    chk("idle_busy", 32'(fetch_busy), 0);
    chk("idle_underrun", 32'(underrun), 0);
    chk("idle_ready", 32'(ppu_wr_ready), 0);
    chk("idle_ram_we", 32'(ram_we), 0);
    chk("idle_ram_addr", 32'(ram_addr), 0);
    chk("idle_ram_wdata", 32'(ram_wdata), 0);

    // uncontested fetch of line 5
    line_req = 1'b1;
    line_num = 8'd5;
    cyc();
    line_req = 1'b0;
    run_fetch(1'b0, 800, busy, reads, bad);
    chk("unc_busy_cycles", 32'(busy), 161);
    chk("unc_reads", 32'(reads), 160);
    chk("unc_addr_bad", 32'(bad), 0);
    swap = 1'b1;
    cyc();
    swap = 1'b0;
    read_line(5);

    // contested fetch of line 7
    line_req     = 1'b1;
    line_num     = 8'd7;
    ppu_wr_valid = 1'b1;
    ppu_wr_addr  = ADDR_W'(16000);
    cyc();
    line_req = 1'b0;
    run_fetch(1'b1, 1120, busy, reads, bad);
    ppu_wr_valid = 1'b0;
    chk("con_busy_cycles", 32'(busy), 321);
    chk("con_reads", 32'(reads), 160);
    chk("con_alt_bad", 32'(bad), 0);
    swap = 1'b1;
    cyc();
    swap = 1'b0;
    read_line(7);

    // PPU writes with no fetch, including the bound
    ppu_wr_valid = 1'b1;
    ppu_wr_addr  = ADDR_W'(10);
    ppu_wr_data  = 2'd3;
    #1;
    chk("wr_ready", 32'(ppu_wr_ready), 1);
    chk("wr_en", 32'(ram_en), 1);
    chk("wr_we", 32'(ram_we), 1);
    chk("wr_addr", 32'(ram_addr), 10);
    chk("wr_data", 32'(ram_wdata), 3);
    cyc();
    ppu_wr_addr = ADDR_W'(FB_PIXELS - 1);
    #1;
    chk("wr_last_en", 32'(ram_en), 1);
    cyc();
    ppu_wr_addr = ADDR_W'(FB_PIXELS);
    #1;
    chk("wr_oob_ready", 32'(ppu_wr_ready), 1);
    chk("wr_oob_en", 32'(ram_en), 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      ppu_wr_addr = ADDR_W'(20000 + i);
      #1;
      if (ppu_wr_ready !== 1'b1) bad++;
    end
    chk("wr_ready_run", 32'(bad), 0);
    ppu_wr_valid = 1'b0;
    cyc();

    // underrun: swap at cycle 50, then a second request
    line_req = 1'b1;
    line_num = 8'd9;
    cyc();
    line_req = 1'b0;
    repeat (49) cyc();
    chk("ur_pre", 32'(underrun), 0);
    swap = 1'b1;
    cyc();
    swap = 1'b0;
    chk("ur_set", 32'(underrun), 1);
    line_req = 1'b1;
    line_num = 8'd3;
    cyc();
    line_req = 1'b0;
    run_fetch(1'b0, 1440 + 51, busy, reads, bad);
    chk("ur_rest_reads", 32'(reads), 109);
    chk("ur_rest_bad", 32'(bad), 0);
    chk("ur_sticky", 32'(underrun), 1);
    cyc();
    chk("ur_no_restart", 32'(fetch_busy), 0);

    // reset in cycle 80 of a fetch
    line_req = 1'b1;
    line_num = 8'd20;
    cyc();
    line_req = 1'b0;
    pix_x = 8'd1;
    repeat (9) cyc();
    swap = 1'b1;
    cyc();
    swap = 1'b0;
    chk("rm_ur_set", 32'(underrun), 1);
    repeat (69) cyc();
    chk("rm_busy_pre", 32'(fetch_busy), 1);
    fbclk_rst = 1'b1;
    cyc();
    chk("rm_busy", 32'(fetch_busy), 0);
    chk("rm_ram_en", 32'(ram_en), 0);
    chk("rm_underrun", 32'(underrun), 0);
    chk("rm_pix", 32'(pix_data), 0);
    fbclk_rst = 1'b0;
    cyc();

    // out-of-range line is ignored
    line_req = 1'b1;
    line_num = 8'd144;
    cyc();
    line_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (fetch_busy !== 1'b0 || ram_en !== 1'b0) bad++;
      cyc();
    end
    chk("edge_144_quiet", 32'(bad), 0);
    chk("edge_144_underrun", 32'(underrun), 0);

    // swap with line_req: fetch fills the post-swap back
    swap     = 1'b1;
    line_req = 1'b1;
    line_num = 8'd10;
    cyc();
    swap     = 1'b0;
    line_req = 1'b0;
    run_fetch(1'b0, 1600, busy, reads, bad);
    chk("sw_busy_cycles", 32'(busy), 161);
    chk("sw_underrun", 32'(underrun), 0);
    swap = 1'b1;
    cyc();
    swap = 1'b0;
    read_line(10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_scanout_arbiter.md
# fb_scanout_arbiter

Shares the single-port Game Boy framebuffer RAM between PPU pixel writes and DVI scanout line prefetch, and holds a ping-pong line buffer that the DVI pixel path reads each display line. It sits between the PPU and the fbclk-domain DVI output stage. It sequences one 160-pixel line fetch per request and arbitrates RAM cycles round-robin against PPU writes.

## Interface
- FB_W, 160, pixels per Game Boy line
- FB_H, 144, Game Boy lines
- PIX_W, 2, bits per pixel (shade index)
- ADDR_W, 15, framebuffer RAM address width (FB_W*FB_H = 23040 words)

Ports:
- fbclk  in  1  pixel clock; the block's only clock
- fbclk_rst  in  1  reset; synchronous and active-high
- line_req  in  1  pulse: prefetch line line_num into the back buffer
- line_num  in  8  Game Boy line index, 0..FB_H-1
- swap  in  1  pulse: exchange front and back buffers (display line boundary)
- ppu_wr_valid  in  1  PPU write request
- ppu_wr_ready  out  1  PPU write accepted this cycle
- ppu_wr_addr  in  ADDR_W  pixel address, y*160+x
- ppu_wr_data  in  PIX_W  pixel value
- ram_en, ram_we  out  1  RAM strobe and write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  PIX_W  RAM write data
- ram_rdata  in  PIX_W  RAM read data, valid 1 cycle after a read strobe
- pix_x  in  8  front-buffer read index
- pix_data  out  PIX_W  registered front-buffer pixel
- fetch_busy  out  1  line fetch in progress
- underrun  out  1  sticky error flag

## Operation
- The FSM has two states: IDLE and FETCH.
- **IDLE, line_req=1, line_num<FB_H:**
  - Latch base = line_num*160, computed as (line_num<<7)+(line_num<<5), zero-extended to ADDR_W.
  - Clear read counter rx and go to FETCH.
- **IDLE, line_req=1, line_num>=FB_H:** the request is ignored. No fetch starts and no flag is set.
- **FETCH, line_req=1:** the request is ignored and underrun is set.
- **FETCH read pending:** a read is pending while rx<FB_W. A granted read drives ram_en=1, ram_we=0, ram_addr=base+rx, then increments rx.
- **Read capture:** the captured-index register cx captures ram_rdata into back[cx] on the cycle after each granted read.
- **FETCH exit:** the FSM returns to IDLE on the cycle cx=FB_W-1 is captured.
- **Arbitration:**
  - Requesters are the PPU (ppu_wr_valid) and the fetch (read pending).
  - When only one requests, it is granted.
  - When both request, the grant goes to the one not granted in the last contested cycle. A `last` register holds this; reset value = fetch, so the PPU wins the first contest.
  - At most one RAM access occurs per cycle.
- **PPU grant:** ppu_wr_ready=1, ram_en=1, ram_we=1, ram_addr=ppu_wr_addr, ram_wdata=ppu_wr_data.
  - If ppu_wr_addr>=23040, the write is accepted but ram_en=0 (dropped).
- **swap:** toggles the front select.
  - If fetch_busy=1 at swap, swap still happens and underrun is set.
  - If swap and line_req arrive in the same cycle, swap is applied first and the fetch fills the new back buffer.
- **pix_data:** pix_data <= front[pix_x] when pix_x<FB_W; otherwise 0.
- **underrun:** cleared only by reset.

## Timing
- **Reset values:**
  - FSM in IDLE, front select=0, last=fetch.
  - fetch_busy=0, underrun=0, pix_data=0.
  - ppu_wr_ready=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - Buffer contents are undefined.
- **Reset mid-fetch:** aborts the fetch immediately. The partially filled buffer is not cleared.
- **ppu_wr_ready:** combinational from ppu_wr_valid and grant. A write completes in the cycle valid&ready.
- **Uncontested fetch:**
  - line_req sampled at edge 0; fetch_busy=1 in cycles 1..161.
  - Reads are issued in cycles 1..160; the last capture is at the end of cycle 161.
  - fetch_busy=0 from cycle 162.
- **Fetch against continuous ppu_wr_valid:**
  - Reads are issued in cycles 2,4,..,320.
  - fetch_busy=1 in cycles 1..321.
- **pix_data latency:** one cycle from pix_x.
- **Back-buffer write vs swap:** a back-buffer write and a swap in the same cycle write the pre-swap back buffer.

## Structure
- **Package fb_pkg:** FB_W, FB_H, FB_PIXELS=23040, PIX_W, ADDR_W, and the state enum {IDLE, FETCH}.
- **Sub-module fb_line_buffer:** 2×FB_W×PIX_W ping-pong storage with a front select bit.
  - Write port targets the back buffer.
  - Registered read port reads the front buffer, with out-of-range read returning 0.
- **Top level:** FSM, counters, arbiter and RAM mux.

## Test plan
- **Uncontested fetch:** preload RAM[y*160+x]=(x+y)&3; line_req with line_num=5, then swap after fetch_busy falls. Required: fetch_busy high exactly 161 cycles, then pix_x=0..159 returns (x+5)&3 with 1-cycle latency, and pix_x=200 returns 0.
- **Contested fetch:** hold ppu_wr_valid=1 throughout the fetch with addresses outside line 5. Required: grants alternate with the PPU first, fetch_busy is high 321 cycles, and line data is correct.
- **Write priority / bounds:** with no fetch active, ppu_wr_ready=1 every cycle. A write to address 23040 gives ready=1 and ram_en=0.
- **Underrun:** issue swap at cycle 50 of a fetch → underrun=1 and stays set. A second line_req during FETCH is ignored and underrun remains 1.
- **Edge requests:** line_req with line_num=144 → no RAM reads and fetch_busy stays 0. swap and line_req in the same cycle → the fetch fills the new back buffer.
- **Reset mid-fetch:** assert fbclk_rst at cycle 80 of a fetch → next cycle fetch_busy=0, ram_en=0, underrun=0, pix_data=0.
